// File: rtl/tff_counter.sv
// -----------------------------------------------------------------------------
// tff_counter
//   Multi-mode register bank. Each edge it either toggles individual bits
//   (a bank of independent T flip-flops), counts up, counts down or holds.
//   The counting modes stay inside 0..MAX_VAL and either wrap or saturate at
//   the limits. A synchronous parallel load overrides the mode for that edge.
//
// Parameters
//   WIDTH    bank/counter width in bits (2..32)
//   MAX_VAL  upper count bound for the counting modes (1..2^WIDTH-1)
//   SAT      boundary policy: 0 = wrap, 1 = saturate
//
// Ports
//   clk      rising-edge clock
//   rstn     asynchronous active-low reset, clears q/tc/ovf
//   en       enable for toggle/count in the current cycle
//   mode     00 toggle, 01 count up, 10 count down, 11 hold
//   t        per-bit toggle request (mode 00 only)
//   load     synchronous parallel load strobe (highest priority)
//   din      parallel load value
//   clr_ovf  synchronous clear of the sticky overflow flag
//   q        registered state
//   tc       one-cycle terminal-count pulse, registered
//   ovf      sticky boundary flag, registered
// -----------------------------------------------------------------------------
module tff_counter #(
    parameter int WIDTH   = 8,
    parameter int MAX_VAL = 255,
    parameter int SAT     = 0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] t,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    typedef enum logic [1:0] {
        MODE_TOGGLE = 2'b00,
        MODE_UP     = 2'b01,
        MODE_DOWN   = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_t;

    localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ZERO_Q = '0;
    localparam logic [WIDTH-1:0] ONE_Q  = WIDTH'(1);

    logic [WIDTH-1:0] q_next;
    logic             tc_next;
    logic             boundary;
    mode_t            mode_e;

    assign mode_e = mode_t'(mode);

    always_comb begin
        q_next   = q;
        tc_next  = 1'b0;
        boundary = 1'b0;
        if (load) begin
            // The toggle bank has no notion of a count range, so only the
            // counting/hold modes clamp the loaded value.
            if (mode_e == MODE_TOGGLE)
                q_next = din;
            else
                q_next = (din > MAX_Q) ? MAX_Q : din;
        end else if (en) begin
            case (mode_e)
                MODE_TOGGLE: q_next = q ^ t;
                MODE_UP: begin
                    if (q >= MAX_Q) begin
                        q_next   = (SAT != 0) ? MAX_Q : ZERO_Q;
                        boundary = 1'b1;
                    end else begin
                        q_next = q + ONE_Q;
                    end
                end
                MODE_DOWN: begin
                    if (q == ZERO_Q) begin
                        q_next   = (SAT != 0) ? ZERO_Q : MAX_Q;
                        boundary = 1'b1;
                    end else if (q > MAX_Q) begin
                        // Out-of-range value (from a toggle-mode load) is
                        // pulled back into range rather than decremented.
                        q_next = MAX_Q;
                    end else begin
                        q_next = q - ONE_Q;
                    end
                end
                default: q_next = q;
            endcase
            tc_next = boundary;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q   <= '0;
            tc  <= 1'b0;
            ovf <= 1'b0;
        end else begin
            q  <= q_next;
            tc <= tc_next;
            // A boundary event in the same cycle as a clear keeps the flag set.
            if (boundary)
                ovf <= 1'b1;
            else if (clr_ovf)
                ovf <= 1'b0;
        end
    end

endmodule
